// File: rtl/div_pipe.sv
// Pipelined restoring divider: BITS_PER_STAGE quotient bits per stage, global stall, RISC-V div/rem semantics.
// Optional macro DIV_PIPE_OUT_REG_EN registers the sign fix-up and special-case mux (latency STAGES+1).

module div_pipe_stage #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 4
) (
  input  logic [2*WIDTH-1:0] i_rem,
  input  logic [2*WIDTH-1:0] i_div,
  input  logic [WIDTH-1:0]   i_q,
  output logic [2*WIDTH-1:0] o_rem,
  output logic [2*WIDTH-1:0] o_div,
  output logic [WIDTH-1:0]   o_q
);
  logic [2*WIDTH-1:0] w_rem, w_div;
  logic [WIDTH-1:0]   w_q;

  always_comb begin
    w_rem = i_rem;
    w_div = i_div;
    w_q   = i_q;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      if (w_rem >= w_div) begin
        w_rem = w_rem - w_div;
        w_q   = {w_q[WIDTH-2:0], 1'b1};
      end else begin
        w_q   = {w_q[WIDTH-2:0], 1'b0};
      end
      w_div = w_div >> 1;
    end
  end

  assign o_rem = w_rem;
  assign o_div = w_div;
  assign o_q   = w_q;
endmodule

module div_pipe #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_t,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz
);
  localparam int STAGES = WIDTH / BITS_PER_STAGE;
  localparam int W2     = 2 * WIDTH;

  typedef struct packed {
    logic [W2-1:0]    rem;
    logic [W2-1:0]    div;
    logic [WIDTH-1:0] q;
    logic             qsign;
    logic             rsign;
    logic             dbz;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // r_st[0] holds the prepared operands; r_st[k] has k groups of quotient bits resolved.
  stage_t            r_st [STAGES+1];
  logic [STAGES:0]   r_vld_pipe;
  stage_t            w_nxt [STAGES];
  logic [W2-1:0]     w_rem [STAGES];
  logic [W2-1:0]     w_div [STAGES];
  logic [WIDTH-1:0]  w_q   [STAGES];

  stage_t            w_entry;
  logic              w_ssign, w_tsign, w_adv;
  logic [WIDTH-1:0]  w_sabs, w_tabs;

  always_comb begin
    w_ssign = in_signed & in_s[WIDTH-1];
    w_tsign = in_signed & in_t[WIDTH-1];
    w_sabs  = w_ssign ? (~in_s + 1'b1) : in_s;
    w_tabs  = w_tsign ? (~in_t + 1'b1) : in_t;
    w_entry       = '0;
    w_entry.rem   = {{WIDTH{1'b0}}, w_sabs};
    w_entry.div   = {{WIDTH{1'b0}}, w_tabs} << (WIDTH-1);
    w_entry.qsign = w_ssign ^ w_tsign;
    w_entry.rsign = w_ssign;
    w_entry.dbz   = (in_t == '0);
    w_entry.ovf   = in_signed && (in_s == {1'b1, {(WIDTH-1){1'b0}}}) && (in_t == {WIDTH{1'b1}});
    w_entry.tag   = in_tag;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    div_pipe_stage #(.WIDTH(WIDTH), .BITS_PER_STAGE(BITS_PER_STAGE)) u_stg (
      .i_rem(r_st[k].rem), .i_div(r_st[k].div), .i_q(r_st[k].q),
      .o_rem(w_rem[k]),    .o_div(w_div[k]),    .o_q(w_q[k])
    );
    assign w_nxt[k] = {w_rem[k], w_div[k], w_q[k], r_st[k].qsign, r_st[k].rsign,
                       r_st[k].dbz, r_st[k].ovf, r_st[k].tag};
  end

  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      for (int k = 0; k <= STAGES; k++) r_st[k] <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
      r_st[0]    <= in_valid ? w_entry : '0;
      for (int k = 0; k < STAGES; k++) r_st[k+1] <= w_nxt[k];
    end
  end

  // Divide-by-zero needs no stored dividend: subtracting 0 leaves |s|, and re-signing it restores s.
  logic [WIDTH-1:0] w_mag_q, w_mag_r, w_fix_q, w_fix_r;
  always_comb begin
    w_mag_q = r_st[STAGES].q;
    w_mag_r = r_st[STAGES].rem[WIDTH-1:0];
    w_fix_q = r_st[STAGES].qsign ? (~w_mag_q + 1'b1) : w_mag_q;
    w_fix_r = r_st[STAGES].rsign ? (~w_mag_r + 1'b1) : w_mag_r;
    if (r_st[STAGES].dbz) begin
      w_fix_q = {WIDTH{1'b1}};
    end else if (r_st[STAGES].ovf) begin
      w_fix_q = {1'b1, {(WIDTH-1){1'b0}}};
      w_fix_r = '0;
    end
  end

`ifdef DIV_PIPE_OUT_REG_EN
  logic             r_out_vld, r_out_dbz;
  logic [WIDTH-1:0] r_out_q, r_out_r;
  logic [TAG_W-1:0] r_out_tag;

  assign w_adv = !r_out_vld || out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_vld <= 1'b0;
      r_out_q   <= '0;
      r_out_r   <= '0;
      r_out_tag <= '0;
      r_out_dbz <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= r_vld_pipe[STAGES];
      r_out_q   <= w_fix_q;
      r_out_r   <= w_fix_r;
      r_out_tag <= r_st[STAGES].tag;
      r_out_dbz <= r_st[STAGES].dbz;
    end
  end

  assign out_valid = r_out_vld;
  assign out_q     = r_out_q;
  assign out_r     = r_out_r;
  assign out_tag   = r_out_tag;
  assign out_dbz   = r_out_dbz;
`else
  assign w_adv     = !r_vld_pipe[STAGES] || out_ready;
  assign out_valid = r_vld_pipe[STAGES];
  assign out_q     = w_fix_q;
  assign out_r     = w_fix_r;
  assign out_tag   = r_st[STAGES].tag;
  assign out_dbz   = r_st[STAGES].dbz;
`endif
endmodule

// File: tb/tb_div_pipe.sv
// Bench for div_pipe: arithmetic reference model + scoreboard queue, directed vectors, backpressure, async reset.
module tb_div_pipe;
  localparam int STAGES = 8;
`ifdef DIV_PIPE_OUT_REG_EN
  localparam int LAT = STAGES + 1;
`else
  localparam int LAT = STAGES;
`endif

  logic        clk = 0, rstn = 0;
  logic        in_valid = 0, in_signed = 0, out_ready = 1;
  logic [31:0] in_s = 0, in_t = 0;
  logic [4:0]  in_tag = 0;
  logic        in_ready, out_valid, out_dbz;
  logic [31:0] out_q, out_r;
  logic [4:0]  out_tag;

  div_pipe #(.WIDTH(32), .BITS_PER_STAGE(4), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_s(in_s), .in_t(in_t), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_tag(out_tag), .out_dbz(out_dbz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [4:0]  tag;
    logic        dbz;
  } exp_t;

  exp_t        expq[$];
  exp_t        e;
  int          total = 0, bad = 0, ndone = 0;
  logic        prev_stall = 0;
  logic [31:0] sv_q, sv_r;
  logic [4:0]  sv_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference: plain truncating division with RISC-V special cases.
  function automatic void model(input logic [31:0] s, input logic [31:0] t, input logic sg,
                                output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint a, b;
    dbz = (t == 0);
    if (t == 0) begin
      q = 32'hFFFF_FFFF; r = s;
    end else if (!sg) begin
      q = s / t; r = s % t;
    end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else begin
      a = longint'($signed(s)); b = longint'($signed(t));
      q = 32'(a / b); r = 32'(a % b);
    end
  endfunction

  // Scoreboard: every cycle the outputs are meaningful.
  always @(negedge clk) begin
    if (!rstn) prev_stall = 0;
    else begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
      if (prev_stall) begin
        chk("stall_q", out_q, sv_q);
        chk("stall_r", out_r, sv_r);
        chk("stall_tag", {27'b0, out_tag}, {27'b0, sv_tag});
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid got=1 want=0 tag=%0d", out_tag);
        end else begin
          e = expq[0];
          chk("sb_q", out_q, e.q);
          chk("sb_r", out_r, e.r);
          chk("sb_tag", {27'b0, out_tag}, {27'b0, e.tag});
          chk("sb_dbz", {31'b0, out_dbz}, {31'b0, e.dbz});
          if (out_ready) begin
            void'(expq.pop_front());
            ndone++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        model(in_s, in_t, in_signed, n.q, n.r, n.dbz);
        n.tag = in_tag;
        expq.push_back(n);
      end
      prev_stall = out_valid && !out_ready;
      sv_q = out_q; sv_r = out_r; sv_tag = out_tag;
    end
  end

  // One operation on an idle pipe, checked against literal expectations and exact latency.
  task automatic run1(input string nm, input logic sg, input logic [31:0] s, input logic [31:0] t,
                      input logic [4:0] tag, input logic [31:0] eq, input logic [31:0] er, input logic ed);
    int n;
    in_signed = sg; in_s = s; in_t = t; in_tag = tag; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, n, LAT);
    chk({nm, "_q"}, out_q, eq);
    chk({nm, "_r"}, out_r, er);
    chk({nm, "_tag"}, {27'b0, out_tag}, {27'b0, tag});
    chk({nm, "_dbz"}, {31'b0, out_dbz}, {31'b0, ed});
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while (expq.size() != 0 && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    logic [31:0] mq, mr;
    logic        md;
    int          base;

    // Pin the reference model itself.
    model(32'd100, 32'd7, 1'b0, mq, mr, md);
    chk("model_100_7_q", mq, 32'd14); chk("model_100_7_r", mr, 32'd2);
    model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, md);
    chk("model_m7_2_q", mq, 32'hFFFF_FFFD); chk("model_m7_2_r", mr, 32'hFFFF_FFFF);
    model(32'hFFFF_FFFB, 32'd0, 1'b1, mq, mr, md);
    chk("model_dbz_r", mr, 32'hFFFF_FFFB); chk("model_dbz_f", {31'b0, md}, 32'd1);

    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_q", out_q, 32'd0);
    chk("rst_r", out_r, 32'd0);
    chk("rst_tag", {27'b0, out_tag}, 32'd0);
    chk("rst_dbz", {31'b0, out_dbz}, 32'd0);
    #11 rstn = 1;
    @(posedge clk); #1;

    run1("u100_7",  0, 32'd100,       32'd7,          5'd3,  32'd14,        32'd2,        0);
    run1("sm7_2",   1, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run1("s7_m2",   1, 32'd7,         32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD, 32'd1,        0);
    run1("sm7_m2",  1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  5'd6,  32'd3,         32'hFFFF_FFFF, 0);
    run1("u_f9_2",  0, 32'hFFFF_FFF9, 32'd2,          5'd7,  32'h7FFF_FFFC, 32'd1,        0);
    run1("sdbz",    1, 32'hFFFF_FFFB, 32'd0,          5'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);
    run1("udbz",    0, 32'd9,         32'd0,          5'd9,  32'hFFFF_FFFF, 32'd9,        1);
    run1("sovf",    1, 32'h8000_0000, 32'hFFFF_FFFF,  5'd10, 32'h8000_0000, 32'd0,        0);
    run1("uovf",    0, 32'h8000_0000, 32'hFFFF_FFFF,  5'd11, 32'd0,         32'h8000_0000, 0);

    // Backpressure: 12 back-to-back ops with a 5-cycle output stall mid-stream.
    base = ndone;
    fork
      begin : issue
        int   n, g;
        logic acc;
        n = 0; g = 0;
        in_signed = 1'($urandom); in_s = $urandom; in_t = $urandom >> $urandom_range(0, 31);
        in_tag = 5'(n); in_valid = 1;
        while (n < 12 && g < 200) begin
          @(negedge clk); acc = in_ready;
          @(posedge clk); #1;
          g++;
          if (acc) begin
            n++;
            in_signed = 1'($urandom); in_s = $urandom; in_t = $urandom >> $urandom_range(0, 31);
            in_tag = 5'(n);
          end
        end
        in_valid = 0;
        chk("bp_issued", n, 12);
      end
      begin : stall
        repeat (10) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain(100);
    chk("bp_results", ndone - base, 12);

    // Reset with 4 operations in flight, the oldest held at the output.
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_signed = 0; in_s = 32'd1000 + i; in_t = 32'd3; in_tag = 5'(20 + i); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    begin
      int g = 0;
      while (!out_valid && g < 40) begin
        @(posedge clk); #1;
        g++;
      end
    end
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #2;
    rstn = 0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
    expq.delete();
    #9 rstn = 1;
    out_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_quiet", {31'b0, out_valid}, 32'd0);
    run1("post_20_6", 0, 32'd20, 32'd6, 5'd1, 32'd3, 32'd2, 0);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
